// File: rtl/store_merge_buffer_if.sv
// Store-path bus bundle: pipeline store/load ports and the memory drain port.
// slave is the buffer's view; master is the pipeline/memory side.
interface store_merge_buffer_if #(
   parameter int DATA_W = 32
) ();
   localparam int BYTES = DATA_W / 8;

   logic              st_valid;
   logic [1:0]        st_size;
   logic [31:0]       st_addr;
   logic [DATA_W-1:0] st_data;
   logic              st_ready;
   logic              st_exc;

   logic              ld_valid;
   logic [31:0]       ld_addr;
   logic              ld_hazard;

   logic              mem_valid;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [BYTES-1:0]  mem_be;
   logic              mem_ready;

   modport slave (
      input  st_valid, st_size, st_addr, st_data,
      output st_ready, st_exc,
      input  ld_valid, ld_addr,
      output ld_hazard,
      output mem_valid, mem_addr, mem_data, mem_be,
      input  mem_ready
   );

   modport master (
      output st_valid, st_size, st_addr, st_data,
      input  st_ready, st_exc,
      output ld_valid, ld_addr,
      input  ld_hazard,
      input  mem_valid, mem_addr, mem_data, mem_be,
      output mem_ready
   );
endinterface

// File: rtl/store_merge_buffer.sv
// Store queue between MEM and the data bus: lane placement, address-map
// checks, same-word merging into the youngest entry, in-order drain.
module store_merge_buffer #(
   parameter int          DATA_W  = 32,
   parameter int          DEPTH   = 4,
   parameter logic [31:0] MEM_LSA = 32'h0000_0000,
   parameter logic [31:0] MEM_MSA = 32'h0000_2FFF,
   parameter logic [31:0] IO_LSA  = 32'h0000_7F00,
   parameter logic [31:0] IO_MSA  = 32'h0000_7F2B
) (
   input  logic                       clk,
   input  logic                       reset,
   store_merge_buffer_if.slave        bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   localparam logic [31:0]   WMASK = ~((32'd1 << OFF) - 32'd1);
   localparam logic [PW-1:0] ONE_P = 1;

   logic [31:0]       addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [BYTES-1:0]  be_q   [DEPTH];
   logic [PW-1:0]     head, tail, young;
   logic [CW-1:0]     cnt_q, cnt_after;

   logic              in_mem, in_io, mis, bad;
   logic [31:0]       st_word, ld_word;
   logic [OFF-1:0]    off;
   logic [OFF+2:0]    sh;
   logic [BYTES-1:0]  raw_be, new_be;
   logic [DATA_W-1:0] raw_data, new_data;
   logic              full, accept, pop, merge, alloc;
   logic              hit;
   logic [PW-1:0]     rel;

   // Unsigned offset compare keeps the range check free of >= 0 terms.
   assign in_mem = (bus.st_addr - MEM_LSA) <= (MEM_MSA - MEM_LSA);
   assign in_io  = (bus.st_addr - IO_LSA) <= (IO_MSA - IO_LSA);

   always_comb begin
      mis = 1'b0;
      unique case (1'b1)
         bus.st_size == 2'b01: mis = bus.st_addr[0];
         bus.st_size == 2'b10: mis = bus.st_addr[1:0] != 2'b00;
         bus.st_size == 2'b11: mis = bus.st_addr[2:0] != 3'b000;
         default:              mis = 1'b0;
      endcase
   end

   assign bad = !(in_mem || in_io) || mis
              || (bus.st_size == 2'b11 && DATA_W == 32)
              || (in_io && bus.st_size != 2'b10);

   assign bus.st_exc = bus.st_valid && bad;

   assign st_word = bus.st_addr & WMASK;
   assign ld_word = bus.ld_addr & WMASK;
   assign off     = bus.st_addr[OFF-1:0];
   assign sh      = {off, 3'b000};

   always_comb begin
      raw_be   = '0;
      raw_data = '0;
      for (int i = 0; i < BYTES; i++) begin
         raw_be[i] = i < (32'd1 << bus.st_size);
         if (raw_be[i])
            raw_data[8*i +: 8] = bus.st_data[8*i +: 8];
      end
   end

   assign new_be   = raw_be << off;
   assign new_data = raw_data << sh;

   assign full      = cnt_q == CW'(DEPTH);
   assign empty     = cnt_q == '0;
   assign count     = cnt_q;
   assign young     = tail - ONE_P;
   assign pop       = !empty && bus.mem_ready;
   assign cnt_after = cnt_q - CW'(pop);
   assign accept    = bus.st_valid && !full && !bad;

   // Requiring two entries after the pop keeps the head out of reach.
   assign merge = accept && in_mem
               && cnt_after >= CW'(2)
               && addr_q[young] == st_word;
   assign alloc = accept && !merge;

   assign bus.st_ready  = !full;
   assign bus.mem_valid = !empty;
   assign bus.mem_addr  = addr_q[head];
   assign bus.mem_data  = data_q[head];
   assign bus.mem_be    = be_q[head];

   // Occupancy is the pointer distance from head, so the popping head counts.
   always_comb begin
      hit = 1'b0;
      rel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rel = PW'(i) - head;
         if ({1'b0, rel} < cnt_q && addr_q[i] == ld_word)
            hit = 1'b1;
      end
   end

   assign bus.ld_hazard = bus.ld_valid && hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         if (pop)
            head <= head + ONE_P;
         if (alloc) begin
            addr_q[tail] <= st_word;
            data_q[tail] <= new_data;
            be_q[tail]   <= new_be;
            tail         <= tail + ONE_P;
         end
         if (merge) begin
            be_q[young] <= be_q[young] | new_be;
            for (int i = 0; i < BYTES; i++)
               if (new_be[i])
                  data_q[young][8*i +: 8] <= new_data[8*i +: 8];
         end
         cnt_q <= cnt_q + CW'(alloc) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench for store_merge_buffer: 32-bit and 64-bit instances
// driven from one sequence with hand-computed expectations.
module tb_store_merge_buffer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   store_merge_buffer_if #(.DATA_W(32)) a ();
   store_merge_buffer_if #(.DATA_W(64)) b ();

   logic [2:0] cnt_a, cnt_b;
   logic       empty_a, empty_b;

   store_merge_buffer #(.DATA_W(32)) u32 (
      .clk   (clk),
      .reset (reset),
      .bus   (a.slave),
      .count (cnt_a),
      .empty (empty_a)
   );

   store_merge_buffer #(.DATA_W(64)) u64 (
      .clk   (clk),
      .reset (reset),
      .bus   (b.slave),
      .count (cnt_b),
      .empty (empty_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sa(input logic v, input logic [1:0] sz,
                     input logic [31:0] ad, input logic [31:0] d);
      a.st_valid = v;
      a.st_size  = sz;
      a.st_addr  = ad;
      a.st_data  = d;
   endtask

   task automatic sb(input logic v, input logic [1:0] sz,
                     input logic [31:0] ad, input logic [63:0] d);
      b.st_valid = v;
      b.st_size  = sz;
      b.st_addr  = ad;
      b.st_data  = d;
   endtask

   initial begin
      reset = 1'b1;
      sa(0, 0, 0, 0);
      sb(0, 0, 0, 0);
      a.ld_valid = 0; a.ld_addr = 0; a.mem_ready = 0;
      b.ld_valid = 0; b.ld_addr = 0; b.mem_ready = 0;
      tick();
      tick();
      reset = 1'b0;
      #1;

      check("rst_count", cnt_a, 0);
      check("rst_empty", empty_a, 1);
      check("rst_mvalid", a.mem_valid, 0);
      check("rst_maddr", a.mem_addr, 0);
      check("rst_mdata", a.mem_data, 0);
      check("rst_mbe", a.mem_be, 0);
      check("rst_ready", a.st_ready, 1);
      check("rst_hazard", a.ld_hazard, 0);
      check("rst_exc", a.st_exc, 0);

      // byte store placed on lane 3
      sa(1, 2'b00, 32'h3, 32'hAB);
      #1 check("b3_exc", a.st_exc, 0);
      tick();
      sa(0, 0, 0, 0);
      #1;
      check("b3_mvalid", a.mem_valid, 1);
      check("b3_maddr", a.mem_addr, 32'h0);
      check("b3_mbe", a.mem_be, 4'b1000);
      check("b3_mdata", a.mem_data, 32'hAB00_0000);
      a.mem_ready = 1;
      tick();
      a.mem_ready = 0;
      #1 check("b3_drained", empty_a, 1);

      // illegal stores are flagged and dropped
      sa(1, 2'b01, 32'h11, 32'h1);
      #1 check("exc_half_odd", a.st_exc, 1);
      tick();
      sa(1, 2'b10, 32'h7F06, 32'h1);
      #1 check("exc_io_mis", a.st_exc, 1);
      tick();
      sa(1, 2'b00, 32'h7F00, 32'h1);
      #1 check("exc_io_byte", a.st_exc, 1);
      tick();
      sa(1, 2'b10, 32'h4000, 32'h1);
      #1 check("exc_unmapped", a.st_exc, 1);
      tick();
      sa(1, 2'b00, 32'h3000, 32'h1);
      #1 check("exc_mem_top1", a.st_exc, 1);
      tick();
      sa(1, 2'b11, 32'h8, 32'h1);
      #1 check("exc_dword32", a.st_exc, 1);
      tick();
      sa(0, 0, 0, 0);
      #1 check("exc_count", cnt_a, 0);
      sa(1, 2'b10, 32'h7F04, 32'h1);
      #1 check("ok_io_word", a.st_exc, 0);
      sa(1, 2'b00, 32'h2FFF, 32'h1);
      #1 check("ok_mem_top", a.st_exc, 0);
      sa(0, 0, 0, 0);

      // merge into youngest entry
      sa(1, 2'b10, 32'h0, 32'h1111_1111);
      tick();
      sa(1, 2'b00, 32'h10, 32'h22);
      tick();
      sa(1, 2'b00, 32'h11, 32'h33);
      tick();
      sa(0, 0, 0, 0);
      #1;
      check("mrg_count", cnt_a, 2);
      check("mrg_head_data", a.mem_data, 32'h1111_1111);
      check("mrg_head_be", a.mem_be, 4'b1111);
      a.ld_valid = 1; a.ld_addr = 32'h12;
      #1 check("mrg_hazard", a.ld_hazard, 1);
      a.ld_valid = 0;
      a.mem_ready = 1;
      tick();
      a.mem_ready = 0;
      #1;
      check("mrg_e1_addr", a.mem_addr, 32'h10);
      check("mrg_e1_be", a.mem_be, 4'b0011);
      check("mrg_e1_data", a.mem_data, 32'h0000_3322);
      a.mem_ready = 1;
      tick();
      a.mem_ready = 0;

      // single entry is the head: same-word store must allocate
      sa(1, 2'b00, 32'h20, 32'hAA);
      tick();
      sa(1, 2'b00, 32'h21, 32'hBB);
      tick();
      sa(0, 0, 0, 0);
      #1 check("nomrg_count", cnt_a, 2);
      a.ld_valid = 1; a.ld_addr = 32'h22;
      #1 check("hz_hit", a.ld_hazard, 1);
      a.ld_addr = 32'h24;
      #1 check("hz_miss", a.ld_hazard, 0);
      a.ld_valid = 0; a.ld_addr = 32'h22;
      #1 check("hz_novalid", a.ld_hazard, 0);
      a.mem_ready = 1;
      tick();
      tick();
      a.mem_ready = 0;
      #1 check("hz_drained", empty_a, 1);

      // fill, reject while full, then drain back-to-back
      for (int i = 0; i < 4; i++) begin
         sa(1, 2'b10, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
         tick();
      end
      sa(1, 2'b00, 32'h10C, 32'hFF);
      #1;
      check("full_count", cnt_a, 4);
      check("full_ready", a.st_ready, 0);
      tick();
      sa(0, 0, 0, 0);
      #1 check("full_kept", cnt_a, 4);
      a.mem_ready = 1;
      #1 check("full_pop_ready", a.st_ready, 0);
      for (int i = 0; i < 4; i++) begin
         check("drn_addr", a.mem_addr, 32'h100 + 32'(4 * i));
         check("drn_data", a.mem_data, 32'hA0 + 32'(i));
         tick();
         if (i == 0)
            check("drn_ready", a.st_ready, 1);
      end
      a.mem_ready = 0;
      #1 check("drn_empty", empty_a, 1);

      // 64-bit lanes
      sb(1, 2'b11, 32'h8, 64'h0123_4567_89AB_CDEF);
      #1 check("d_exc", b.st_exc, 0);
      tick();
      sb(0, 0, 0, 0);
      #1;
      check("d_be", b.mem_be, 8'hFF);
      check("d_addr", b.mem_addr, 32'h8);
      check("d_data", b.mem_data, 64'h0123_4567_89AB_CDEF);
      sb(1, 2'b01, 32'hE, 64'hBEEF);
      b.mem_ready = 1;
      tick();
      sb(0, 0, 0, 0);
      b.mem_ready = 0;
      #1;
      check("h_count", cnt_b, 1);
      check("h_be", b.mem_be, 8'hC0);
      check("h_addr", b.mem_addr, 32'h8);
      check("h_data", b.mem_data, 64'hBEEF_0000_0000_0000);
      sb(1, 2'b10, 32'h0, 64'h55);
      tick();
      sb(0, 0, 0, 0);
      #1 check("r_pre", cnt_b, 2);
      b.mem_ready = 1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b.mem_ready = 0;
      #1;
      check("r_count", cnt_b, 0);
      check("r_mvalid", b.mem_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
